// File: rtl/fifo_pkg.sv
// Shared constants, word type and level arithmetic for the FIFO read-side output stage.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int LVL_W = 2;

  localparam logic [LVL_W-1:0] LVL_EMPTY = 2'd0;
  localparam logic [LVL_W-1:0] LVL_ONE   = 2'd1;
  localparam logic [LVL_W-1:0] LVL_FULL  = 2'd2;

  // Commitment ceiling: buffered words plus the in-flight read, net of this cycle's pop.
  localparam logic [LVL_W:0] ISSUE_LIMIT = 3'd2;

  typedef logic [FIFO_DATA_WIDTH-1:0] fifo_word_t;

  function automatic logic [LVL_W:0] level_budget(
    input logic [LVL_W-1:0] level,
    input logic             inflight,
    input logic             pop
  );
    return {1'b0, level} + {{LVL_W{1'b0}}, inflight} - {{LVL_W{1'b0}}, pop};
  endfunction

endpackage

// File: rtl/fifo_fwft_rd_if.sv
// FIFO read port plus the first-word-fall-through output stream of the read-side stage.
interface fifo_fwft_rd_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
);

  logic                  fifo_r_empty;
  logic                  fifo_r_en;
  logic [DATA_WIDTH-1:0] fifo_r_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [LVL_W-1:0]      m_level;

  modport master (
    input  fifo_r_empty,
    input  fifo_r_data,
    input  m_ready,
    output fifo_r_en,
    output m_valid,
    output m_data,
    output m_level
  );

  modport slave (
    output fifo_r_empty,
    output fifo_r_data,
    output m_ready,
    input  fifo_r_en,
    input  m_valid,
    input  m_data,
    input  m_level
  );

endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order output buffer: entry0 is the head, entry1 absorbs an arrival
// while the head is still waiting for the consumer.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_valid,
  output logic [LVL_W-1:0]      level
);

  logic [DATA_WIDTH-1:0] entry0_r;
  logic [DATA_WIDTH-1:0] entry1_r;
  logic [LVL_W-1:0]      level_r;
  logic                  valid_r;

  logic [DATA_WIDTH-1:0] entry0_s;
  logic [DATA_WIDTH-1:0] entry1_s;
  logic [LVL_W-1:0]      level_s;

  // Next-state of both entries and the level for every push/pop combination.
  always_comb begin
    entry0_s = entry0_r;
    entry1_s = entry1_r;
    level_s  = level_r;
    case ({push, pop})
      2'b10: begin
        if (level_r == LVL_EMPTY) begin
          entry0_s = push_data;
          level_s  = LVL_ONE;
        end else if (level_r == LVL_ONE) begin
          entry1_s = push_data;
          level_s  = LVL_FULL;
        end else begin
          // Unreachable: the issue logic never lets a word arrive into a full buffer.
          level_s  = level_r;
        end
      end
      2'b01: begin
        entry0_s = entry1_r;
        level_s  = level_r - LVL_ONE;
      end
      2'b11: begin
        if (level_r == LVL_ONE) begin
          entry0_s = push_data;
        end else begin
          entry0_s = entry1_r;
          entry1_s = push_data;
        end
      end
      default: begin
        level_s = level_r;
      end
    endcase
  end

  // Buffer state register; head_valid is registered from the next level.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry0_r <= '0;
      entry1_r <= '0;
      level_r  <= LVL_EMPTY;
      valid_r  <= 1'b0;
    end else begin
      entry0_r <= entry0_s;
      entry1_r <= entry1_s;
      level_r  <= level_s;
      valid_r  <= (level_s != LVL_EMPTY);
    end
  end

  assign head_data  = entry0_r;
  assign head_valid = valid_r;
  assign level      = level_r;

endmodule

// File: rtl/fifo_fwft_rd.sv
// First-word-fall-through read stage: issues FIFO reads only when the returning word
// is guaranteed a slot, and presents the buffered words as a valid/ready stream.
module fifo_fwft_rd
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
  input logic            r_clk,
  input logic            r_rst,
  fifo_fwft_rd_if.master bus
);

  logic                  inflight_r;
  logic                  rd_en_s;
  logic                  pop_s;
  logic                  head_valid_s;
  logic [DATA_WIDTH-1:0] head_data_s;
  logic [LVL_W-1:0]      level_s;

  assign pop_s = head_valid_s & bus.m_ready;

  // Read issue: combinational so a freed slot is refilled in the same cycle.
  always_comb begin
    rd_en_s = 1'b0;
    if (r_rst) begin
      rd_en_s = 1'b0;
    end else if (bus.fifo_r_empty) begin
      rd_en_s = 1'b0;
    end else begin
      rd_en_s = (level_budget(level_s, inflight_r, pop_s) < ISSUE_LIMIT);
    end
  end

  // In-flight flag: rd_en_s already implies the FIFO accepted the read.
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= rd_en_s;
    end
  end

  fifo_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid_buf (
    .clk        (r_clk),
    .rst        (r_rst),
    .push       (inflight_r),
    .push_data  (bus.fifo_r_data),
    .pop        (pop_s),
    .head_data  (head_data_s),
    .head_valid (head_valid_s),
    .level      (level_s)
  );

  assign bus.fifo_r_en = rd_en_s;
  assign bus.m_valid   = head_valid_s;
  assign bus.m_data    = head_data_s;
  assign bus.m_level   = level_s;

endmodule
